// File: rtl/fc_buff_sched_if.sv
// ============================================================================
// fc_buff_sched_if : stream, buffer-port and status bundle for fc_buff_sched
// Rev 1.0
// ============================================================================
`default_nettype none

interface fc_buff_sched_if #(
  parameter int SRAM_DEPTH = 1024,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_W      = 10
);
  localparam int AW = $clog2(SRAM_DEPTH);

  logic                  start;
  logic [AW:0]           cfg_in_len;
  logic [OUT_W-1:0]      cfg_out_num;
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  wea;
  logic [AW-1:0]         addra;
  logic [DATA_WIDTH-1:0] dia;
  logic                  enb;
  logic [AW-1:0]         addrb;
  logic [DATA_WIDTH-1:0] dob;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, cfg_in_len, cfg_out_num, s_valid, s_data, dob, m_ready,
    output s_ready, wea, addra, dia, enb, addrb, m_valid, m_data, m_last, busy, done
  );

  modport slave (
    output start, cfg_in_len, cfg_out_num, s_valid, s_data, dob, m_ready,
    input  s_ready, wea, addra, dia, enb, addrb, m_valid, m_data, m_last, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/fc_buff_sched.sv
// ============================================================================
// fc_buff_sched : fills the FC activation buffer once, then replays it
//                 cfg_out_num times through a 2-entry skid FIFO.
// Rev 1.0
// ============================================================================
`default_nettype none

module fc_buff_sched #(
  parameter int SRAM_DEPTH = 1024,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_W      = 10
) (
  input  logic             clk,
  input  logic             rstn,
  fc_buff_sched_if.master  bus
);
  localparam int          AW      = $clog2(SRAM_DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(SRAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [AW:0]           len;
  logic [OUT_W-1:0]      num;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [OUT_W-1:0]      vec_cnt;
  logic                  issue_done;
  logic                  inflight, inflight_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  fifo_wp, fifo_rp;
  logic [1:0]            fifo_cnt;

  logic [AW:0]           cfg_len_clip;
  logic                  hs, fill_last, rd_wrap, pop, issue;
  logic [2:0]            occ;

  always_comb begin
    cfg_len_clip = (bus.cfg_in_len > DEPTH_W) ? DEPTH_W : bus.cfg_in_len;
    hs           = (state == FILL) && bus.s_valid;
    fill_last    = ({1'b0, wr_ptr} == (len - 1'b1));
    rd_wrap      = ({1'b0, rd_ptr} == (len - 1'b1));
    pop          = (fifo_cnt != 2'd0) && bus.m_ready;
    // Occupancy next cycle if we do not issue: reads must never outrun the skid slots.
    occ          = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    issue        = (state == REPLAY) && !issue_done && (occ < 3'd2);

    state_nxt = state;
    case (state)
      IDLE:   if (bus.start)
                state_nxt = ((cfg_len_clip == '0) || (bus.cfg_out_num == '0)) ? DONE : FILL;
      FILL:   if (hs && fill_last) state_nxt = REPLAY;
      REPLAY: if (issue_done && (fifo_cnt == 2'd0) && !inflight) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    bus.s_ready = (state == FILL);
    bus.wea     = hs;
    bus.addra   = hs ? wr_ptr : '0;
    bus.dia     = hs ? bus.s_data : '0;
    bus.enb     = issue;
    bus.addrb   = issue ? rd_ptr : '0;
    bus.m_valid = (fifo_cnt != 2'd0);
    bus.m_data  = (fifo_cnt != 2'd0) ? fifo_data[fifo_rp] : '0;
    bus.m_last  = (fifo_cnt != 2'd0) ? fifo_last[fifo_rp] : 1'b0;
    bus.busy    = (state == FILL) || (state == REPLAY);
    bus.done    = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      len           <= '0;
      num           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      vec_cnt       <= '0;
      issue_done    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= '0;
      fifo_wp       <= 1'b0;
      fifo_rp       <= 1'b0;
      fifo_cnt      <= '0;
    end else begin
      state <= state_nxt;

      if ((state == IDLE) && bus.start) begin
        len        <= cfg_len_clip;
        num        <= bus.cfg_out_num;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        vec_cnt    <= '0;
        issue_done <= 1'b0;
      end

      if (hs) wr_ptr <= wr_ptr + 1'b1;

      if (issue) begin
        if (rd_wrap) begin
          rd_ptr <= '0;
          if (vec_cnt == (num - 1'b1)) issue_done <= 1'b1;
          else                         vec_cnt    <= vec_cnt + 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end

      // dob is valid the cycle after enb; the last-word tag travels alongside.
      inflight      <= issue;
      inflight_last <= issue && rd_wrap;
      if (inflight) begin
        fifo_data[fifo_wp] <= bus.dob;
        fifo_last[fifo_wp] <= inflight_last;
        fifo_wp            <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fc_buff_sched.sv
// ============================================================================
// tb_fc_buff_sched : random-stimulus bench with a queue-based replay model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fc_buff_sched;
  localparam int DEPTH = 1024;
  localparam int DW    = 8;
  localparam int OW    = 10;
  localparam int AW    = $clog2(DEPTH);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fc_buff_sched_if #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_W(OW)) bus ();
  fc_buff_sched #(.SRAM_DEPTH(DEPTH), .DATA_WIDTH(DW), .OUT_W(OW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // 1-cycle-read simple dual-port SRAM
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.wea) mem[bus.addra] <= bus.dia;
    if (bus.enb) bus.dob <= mem[bus.addrb];
  end

  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [DW-1:0] src [DEPTH];
  logic [DW-1:0] got_d [$];
  bit            got_l [$];
  int            wr_a  [$];
  logic [DW-1:0] wr_d  [$];
  int n_enb, n_done, n_sready, n_valid, stab_err, both_err;
  int first_v, last_v, first_enb, done_cyc, start_cyc;
  bit prev_hold; logic [DW-1:0] prev_d; logic prev_l;

  always @(negedge clk) begin
    if (bus.m_valid && bus.m_ready) begin got_d.push_back(bus.m_data); got_l.push_back(bus.m_last); end
    if (bus.wea) begin wr_a.push_back(int'(bus.addra)); wr_d.push_back(bus.dia); end
    if (bus.enb) begin n_enb++; if (first_enb < 0) first_enb = cyc; end
    if (bus.wea && bus.enb) both_err++;
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.s_ready) n_sready++;
    if (bus.m_valid) begin n_valid++; if (first_v < 0) first_v = cyc; last_v = cyc; end
    if (rstn && prev_hold && (!bus.m_valid || bus.m_data !== prev_d || bus.m_last !== prev_l)) stab_err++;
    prev_hold = rstn && bus.m_valid && !bus.m_ready;
    prev_d = bus.m_data; prev_l = bus.m_last;
  end

  task automatic clear_mon();
    got_d.delete(); got_l.delete(); wr_a.delete(); wr_d.delete();
    n_enb = 0; n_done = 0; n_sready = 0; n_valid = 0; stab_err = 0; both_err = 0;
    first_v = -1; last_v = -1; first_enb = -1; done_cyc = -1; prev_hold = 0;
  endtask

  task automatic start_job(input int l, input int n);
    bus.start = 1'b1; bus.cfg_in_len = (AW+1)'(l); bus.cfg_out_num = OW'(n);
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cfg_in_len = (AW+1)'($urandom); bus.cfg_out_num = OW'($urandom);
  endtask

  task automatic feed(input int l, input bit gaps, input bit extra_start, output bit ok);
    int i = 0, guard = 0; bit hs;
    while (i < l && guard < 20*l + 100) begin
      bus.s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.s_data  = src[i];
      bus.start   = extra_start && (guard == 5);
      @(negedge clk); hs = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    bus.s_valid = 1'b0; bus.start = 1'b0;
    ok = (i == l);
  endtask

  task automatic wait_done(input bit rnd, input int limit, output bit ok);
    int c = 0;
    while (n_done == 0 && c < limit) begin
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; c++;
    end
    ok = (n_done != 0);
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit ok;
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({bus.s_ready, bus.wea, bus.addra, bus.dia, bus.enb, bus.addrb, bus.m_valid,
         bus.m_data, bus.m_last, bus.busy, bus.done} !== '0) begin
      miscompares++; $display("FAIL reset_por outputs got %h want 0", {bus.s_ready, bus.wea, bus.addra,
        bus.dia, bus.enb, bus.addrb, bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.done});
    end
    @(posedge clk); #1; rstn = 1'b1;
    for (int i = 0; i < 8; i++) src[i] = DW'($urandom);
    clear_mon();
    start_job(8, 4);
    feed(8, 1'b0, 1'b0, ok);
    for (int c = 0; c < 50 && n_valid == 0; c++) begin @(posedge clk); #1; end
    vectors++;
    if (n_valid == 0) begin miscompares++; $display("FAIL reset_reach_replay got no m_valid want m_valid"); end
    rstn = 1'b0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({bus.s_ready, bus.wea, bus.addra, bus.dia, bus.enb, bus.addrb, bus.m_valid,
           bus.m_data, bus.m_last, bus.busy, bus.done} !== '0) begin
        miscompares++; $display("FAIL reset_mid outputs got %h want 0", {bus.s_ready, bus.wea, bus.addra,
          bus.dia, bus.enb, bus.addrb, bus.m_valid, bus.m_data, bus.m_last, bus.busy, bus.done});
      end
    end
    @(posedge clk); #1; rstn = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || n_done != 0) begin
      miscompares++; $display("FAIL reset_idle busy=%b done_cnt=%0d want busy=0 done_cnt=0", bus.busy, n_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok_f, ok_d;
    for (int i = 0; i < 4; i++) src[i] = DW'(i + 1);
    clear_mon();
    start_job(4, 3);
    feed(4, 1'b0, 1'b0, ok_f);
    wait_done(1'b0, 200, ok_d);
    vectors++;
    if (!ok_f || !ok_d) begin miscompares++; $display("FAIL basic_timeout fill=%b done=%b want 1 1", ok_f, ok_d); end
    vectors++;
    if (wr_a.size() != 4) begin miscompares++; $display("FAIL basic_wea_count got %0d want 4", wr_a.size()); end
    for (int k = 0; k < wr_a.size() && k < 4; k++) begin
      vectors++;
      if (wr_a[k] != k || wr_d[k] !== src[k]) begin
        miscompares++; $display("FAIL basic_write[%0d] got a=%0d d=%h want a=%0d d=%h", k, wr_a[k], wr_d[k], k, src[k]);
      end
    end
    vectors++;
    if (got_d.size() != 12) begin miscompares++; $display("FAIL basic_count got %0d want 12", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 12; k++) begin
      vectors++;
      if (got_d[k] !== src[k%4] || got_l[k] !== (k%4 == 3)) begin
        miscompares++; $display("FAIL basic_word[%0d] got %h/%b want %h/%b", k, got_d[k], got_l[k], src[k%4], (k%4 == 3));
      end
    end
    vectors++;
    if (n_valid != 12 || last_v - first_v + 1 != 12) begin
      miscompares++; $display("FAIL basic_no_bubble got valid=%0d span=%0d want 12 12", n_valid, last_v - first_v + 1);
    end
    vectors++;
    if (first_v - first_enb != 2) begin miscompares++; $display("FAIL basic_latency got %0d want 2", first_v - first_enb); end
    vectors++;
    if (n_done != 1 || both_err != 0 || bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_done got done=%0d both=%0d busy=%b want 1 0 0", n_done, both_err, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok_f, ok_d;
    for (int i = 0; i < 4; i++) src[i] = DW'(i + 1);
    clear_mon();
    start_job(4, 3);
    feed(4, 1'b0, 1'b0, ok_f);
    wait_done(1'b1, 400, ok_d);
    vectors++;
    if (!ok_f || !ok_d || got_d.size() != 12) begin
      miscompares++; $display("FAIL bp_count got %0d words done=%b want 12 1", got_d.size(), ok_d);
    end
    for (int k = 0; k < got_d.size() && k < 12; k++) begin
      vectors++;
      if (got_d[k] !== src[k%4] || got_l[k] !== (k%4 == 3)) begin
        miscompares++; $display("FAIL bp_word[%0d] got %h/%b want %h/%b", k, got_d[k], got_l[k], src[k%4], (k%4 == 3));
      end
    end
    vectors++;
    if (stab_err != 0 || n_done != 1) begin
      miscompares++; $display("FAIL bp_stable got unstable=%0d done=%0d want 0 1", stab_err, n_done);
    end
  endtask

  task automatic test_zero_cfg();
    int ls [3] = '{0, 5, 0};
    int ns [3] = '{3, 0, 0};
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      start_job(ls[t], ns[t]);
      repeat (4) @(posedge clk);
      #1;
      vectors++;
      if (n_done != 1 || done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
        miscompares++; $display("FAIL zero_done[%0d] got cnt=%0d dly=%0d want 1 1..2", t, n_done, done_cyc - start_cyc);
      end
      vectors++;
      if (wr_a.size() != 0 || n_enb != 0 || n_sready != 0) begin
        miscompares++; $display("FAIL zero_quiet[%0d] got wea=%0d enb=%0d rdy=%0d want 0 0 0", t, wr_a.size(), n_enb, n_sready);
      end
    end
  endtask

  task automatic test_len_one();
    bit ok_f, ok_d;
    src[0] = 8'hA5;
    clear_mon();
    start_job(1, 5);
    feed(1, 1'b0, 1'b0, ok_f);
    wait_done(1'b0, 100, ok_d);
    vectors++;
    if (!ok_d || got_d.size() != 5) begin miscompares++; $display("FAIL len1_count got %0d want 5", got_d.size()); end
    for (int k = 0; k < got_d.size() && k < 5; k++) begin
      vectors++;
      if (got_d[k] !== 8'hA5 || got_l[k] !== 1'b1) begin
        miscompares++; $display("FAIL len1_word[%0d] got %h/%b want a5/1", k, got_d[k], got_l[k]);
      end
    end
  endtask

  task automatic test_random_jobs();
    bit ok_f, ok_d;
    int l, n, err;
    for (int j = 0; j < 5; j++) begin
      l = $urandom_range(1, 24); n = $urandom_range(1, 5);
      for (int i = 0; i < l; i++) src[i] = DW'($urandom);
      clear_mon();
      start_job(l, n);
      feed(l, 1'b1, 1'b0, ok_f);
      wait_done(1'b1, 2000, ok_d);
      err = 0;
      for (int k = 0; k < got_d.size() && k < l*n; k++)
        if (got_d[k] !== src[k%l] || got_l[k] !== (k%l == l-1)) err++;
      vectors++;
      if (!ok_d || got_d.size() != l*n || err != 0 || stab_err != 0) begin
        miscompares++; $display("FAIL rand_job[%0d] len=%0d num=%0d got words=%0d bad=%0d unstable=%0d want %0d 0 0",
                                j, l, n, got_d.size(), err, stab_err, l*n);
      end
    end
  endtask

  task automatic test_full_depth();
    bit ok_f, ok_d;
    int err = 0;
    for (int i = 0; i < DEPTH; i++) src[i] = DW'($urandom);
    clear_mon();
    start_job(DEPTH + $urandom_range(0, 100), 2);
    bus.cfg_in_len = (AW+1)'(2); bus.cfg_out_num = OW'(1);
    feed(DEPTH, 1'b1, 1'b1, ok_f);
    wait_done(1'b1, 20000, ok_d);
    for (int k = 0; k < wr_a.size(); k++) if (wr_a[k] != k || wr_d[k] !== src[k]) err++;
    vectors++;
    if (!ok_f || wr_a.size() != DEPTH || err != 0) begin
      miscompares++; $display("FAIL full_fill got writes=%0d bad=%0d want %0d 0", wr_a.size(), err, DEPTH);
    end
    err = 0;
    for (int k = 0; k < got_d.size() && k < 2*DEPTH; k++)
      if (got_d[k] !== src[k%DEPTH] || got_l[k] !== (k%DEPTH == DEPTH-1)) err++;
    vectors++;
    if (!ok_d || got_d.size() != 2*DEPTH || err != 0) begin
      miscompares++; $display("FAIL full_replay got words=%0d bad=%0d want %0d 0", got_d.size(), err, 2*DEPTH);
    end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (n_done != 1 || bus.busy !== 1'b0 || stab_err != 0) begin
      miscompares++; $display("FAIL full_extra_start got done=%0d busy=%b unstable=%0d want 1 0 0", n_done, bus.busy, stab_err);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_in_len = '0; bus.cfg_out_num = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_cfg();
    test_len_one();
    test_random_jobs();
    test_full_depth();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
